// File: rtl/serial_demux_capture_pkg.sv
// Lab-wide definitions shared by the 7-to-1 select mux and its receiver.
// Holds the default word geometry and the capture FSM state encodings.
package serial_demux_capture_pkg;

    localparam int DEF_WIDTH = 7;
    localparam int DEF_SEL_W = 3;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = S_IDLE,
        ST_CAPTURE = S_CAPTURE,
        ST_DONE    = S_DONE
    } state_t;

endpackage

// File: rtl/serial_demux_capture.sv
// Rebuilds a WIDTH-bit word sent LSB first, one bit per BitValid strobe.
// Ports: Clock, Resetn (async low), Start, SerialIn, BitValid in;
//        BitIndex, Busy, Done (1-cycle pulse), Out (last word) out.
module serial_demux_capture
    import serial_demux_capture_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Start,
    input  logic             SerialIn,
    input  logic             BitValid,
    output logic [SEL_W-1:0] BitIndex,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Out
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] stage_q, stage_d;
    logic [WIDTH-1:0] out_q, out_d;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            stage_q <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            stage_q <= stage_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        stage_d = stage_q;
        out_d   = out_q;
        unique case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d = ST_CAPTURE;
                    idx_d   = '0;
                    stage_d = '0;
                end
            end
            ST_CAPTURE: begin
                // Start wins over a coincident bit: that bit is dropped.
                if (Start) begin
                    idx_d   = '0;
                    stage_d = '0;
                end else if (BitValid) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (idx_q == SEL_W'(i)) stage_d[i] = SerialIn;
                    end
                    if (idx_q == LAST) begin
                        out_d   = stage_d;
                        idx_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + SEL_W'(1);
                    end
                end
            end
            ST_DONE: begin
                if (Start) begin
                    state_d = ST_CAPTURE;
                    idx_d   = '0;
                    stage_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                stage_d = '0;
            end
        endcase
    end

    assign BitIndex = idx_q;
    assign Busy     = (state_q == ST_CAPTURE);
    assign Done     = (state_q == ST_DONE);
    assign Out      = out_q;

endmodule

// File: tb/tb_serial_demux_capture.sv
// Directed bench for serial_demux_capture.
// Drives and samples on the falling edge; expectations are hand-computed.
module tb_serial_demux_capture;

    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic       Start = 1'b0;
    logic       SerialIn = 1'b0;
    logic       BitValid = 1'b0;
    logic [2:0] BitIndex;
    logic       Busy;
    logic       Done;
    logic [6:0] Out;

    int checks = 0;
    int failures = 0;
    int cyc_n = 0;
    int pulses = 0;
    int t_done1 = 0;

    always #5 Clock = ~Clock;

    serial_demux_capture dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .Start    (Start),
        .SerialIn (SerialIn),
        .BitValid (BitValid),
        .BitIndex (BitIndex),
        .Busy     (Busy),
        .Done     (Done),
        .Out      (Out)
    );

    always @(negedge Clock) if (Done) pulses++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Apply inputs at a falling edge, return at the next falling edge.
    task automatic cyc(input logic s, input logic v, input logic b);
        Start    = s;
        BitValid = v;
        SerialIn = b;
        @(negedge Clock);
        cyc_n++;
        Start    = 1'b0;
        BitValid = 1'b0;
        SerialIn = 1'b0;
    endtask

    // Send a word LSB first with 'gap' idle cycles between bits.
    task automatic send(input logic [6:0] w, input int gap);
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 1'b1, w[i]);
            if (i < 6) begin
                chk("idx_step", 32'(BitIndex), 32'(i + 1));
                chk("no_early_done", 32'(Done), 0);
                for (int g = 0; g < gap; g++) begin
                    cyc(1'b0, 1'b0, 1'b1);
                    chk("idx_hold", 32'(BitIndex), 32'(i + 1));
                end
            end
        end
    endtask

    initial begin
        @(negedge Clock);
        chk("rst_out", 32'(Out), 0);
        chk("rst_idx", 32'(BitIndex), 0);
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_done", 32'(Done), 0);
        Resetn = 1'b1;
        @(negedge Clock);

        // 1: back-to-back bits
        cyc(1'b1, 1'b0, 1'b0);
        chk("t1_busy", 32'(Busy), 1);
        chk("t1_idx0", 32'(BitIndex), 0);
        send(7'h4D, 0);
        chk("t1_done", 32'(Done), 1);
        chk("t1_out", 32'(Out), 32'h4D);
        chk("t1_busy_done", 32'(Busy), 0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t1_done_off", 32'(Done), 0);
        chk("t1_busy_off", 32'(Busy), 0);

        // 2: gaps of 3 cycles
        cyc(1'b1, 1'b0, 1'b0);
        send(7'h4D, 3);
        chk("t2_done", 32'(Done), 1);
        chk("t2_out", 32'(Out), 32'h4D);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t2_done_off", 32'(Done), 0);

        // 3: restart mid-frame, restart-cycle bit discarded
        cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1);
        chk("t3_idx4", 32'(BitIndex), 4);
        cyc(1'b1, 1'b1, 1'b1);
        chk("t3_restart_idx", 32'(BitIndex), 0);
        chk("t3_restart_busy", 32'(Busy), 1);
        chk("t3_out_kept", 32'(Out), 32'h4D);
        send(7'h00, 0);
        chk("t3_done", 32'(Done), 1);
        chk("t3_out", 32'(Out), 0);
        cyc(1'b0, 1'b0, 1'b0);

        // 4: async reset mid-frame
        cyc(1'b1, 1'b0, 1'b0);
        send(7'h7F, 0);
        chk("t4_out7f", 32'(Out), 32'h7F);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1);
        #2 Resetn = 1'b0;
        #1;
        chk("t4_rst_out", 32'(Out), 0);
        chk("t4_rst_idx", 32'(BitIndex), 0);
        chk("t4_rst_busy", 32'(Busy), 0);
        chk("t4_rst_done", 32'(Done), 0);
        @(negedge Clock);
        @(negedge Clock);
        Resetn = 1'b1;
        @(negedge Clock);

        // 5: Start during DONE skips IDLE
        cyc(1'b1, 1'b0, 1'b0);
        send(7'h11, 0);
        chk("t5_done1", 32'(Done), 1);
        chk("t5_out1", 32'(Out), 32'h11);
        t_done1 = cyc_n;
        cyc(1'b1, 1'b0, 1'b0);
        chk("t5_busy", 32'(Busy), 1);
        chk("t5_idx0", 32'(BitIndex), 0);
        send(7'h2A, 0);
        chk("t5_done2", 32'(Done), 1);
        chk("t5_out2", 32'(Out), 32'h2A);
        chk("t5_spacing", 32'(cyc_n - t_done1), 8);
        cyc(1'b0, 1'b0, 1'b0);

        // 6: BitValid ignored in IDLE
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, i[0], 1'b1);
            chk("t6_out", 32'(Out), 32'h2A);
            chk("t6_idx", 32'(BitIndex), 0);
            chk("t6_busy", 32'(Busy), 0);
            chk("t6_done", 32'(Done), 0);
        end

        chk("pulse_total", 32'(pulses), 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1);
    end

endmodule

// File: doc/serial_demux_capture.md
Name: serial_demux_capture

Overview:
Receive-side counterpart of the 7-to-1 select mux used by the lab designs. The mux sends one bit of a 7-bit word at a time, chosen by a 3-bit select. This block rebuilds the word.
- Accepts one serial bit per strobe, LSB first.
- Steers each bit into position BitIndex of a staging register.
- Publishes the full word on Out with a one-cycle Done pulse.
- Sits on board top level between SW/KEY-driven serial stimulus and LEDR/HEX display.

Parameters:
WIDTH, 7, number of bits per word (number of mux data inputs).
SEL_W, 3, width of BitIndex; must satisfy 2**SEL_W >= WIDTH.

Ports:
Clock  input  1  rising-edge system clock.
Resetn  input  1  asynchronous, active-low reset.
Start  input  1  begin (or restart) capture of a word.
SerialIn  input  1  serial data bit, sampled when BitValid=1.
BitValid  input  1  strobe: SerialIn holds a valid bit this cycle.
BitIndex  output  SEL_W  position the next accepted bit will be written to.
Busy  output  1  high while in CAPTURE.
Done  output  1  one-cycle pulse: Out updated with a complete word.
Out  output  WIDTH  last completed word; held until the next word completes.

Behaviour:
- Interface decision: one clock (Clock); reset is asynchronous and active-low (Resetn).
- Reset (Resetn=0, takes effect immediately, no clock needed):
  - state=IDLE.
  - BitIndex=0, staging=0, Out=0, Done=0, Busy=0.
- All outputs are registered or decoded from registered state. No combinational path from inputs to outputs.
- States: IDLE, CAPTURE, DONE. Encodings are localparams in the package.
- IDLE:
  - Busy=0, Done=0. BitValid is ignored.
  - Start=1 -> CAPTURE next cycle, with BitIndex=0 and staging cleared.
- CAPTURE (Busy=1):
  - BitValid=1 and Start=0: staging[BitIndex] <= SerialIn.
    - If BitIndex == WIDTH-1: Out <= staging with the new bit merged; BitIndex <= 0; go to DONE.
    - Otherwise: BitIndex <= BitIndex+1.
  - BitValid=0: hold all state. Gaps of any length are allowed and there is no timeout.
  - Start=1 (with or without BitValid): restart. staging cleared, BitIndex <= 0, stay in CAPTURE. That cycle's bit is discarded; Start has priority.
- DONE:
  - Done=1 for exactly this cycle; Busy=0.
  - Out already holds the new word.
  - Next state is CAPTURE if Start=1 (BitIndex=0, staging cleared), else IDLE.
  - BitValid is ignored in DONE.
- Latency: Out and Done are both first visible in the cycle after the clock edge that accepted bit WIDTH-1.
- Minimum frame time: 1 Start cycle + WIDTH bit cycles + 1 DONE cycle.
- BitIndex never exceeds WIDTH-1. It wraps to 0 only on completion or restart. Values WIDTH..2**SEL_W-1 are unreachable.
- Out changes only on completion or reset. An aborted or restarted frame never alters Out.

Decomposition:
- Shared package (lab-wide):
  - state encoding localparams S_IDLE=2'd0, S_CAPTURE=2'd1, S_DONE=2'd2.
  - default WIDTH=7, SEL_W=3, so the mux and this block agree on word size.
- No sub-module required. The index counter and staging register are inline.
- Board wrapper top_serial_demux maps:
  - Clock=CLOCK_50, Resetn=KEY[0], Start=KEY[1] edge-detected, SerialIn=SW[0], BitValid=KEY[2] edge-detected.
  - Out to LEDR[6:0], Done to LEDR[9].
- The wrapper is separate from this block.

Test Plan:
1. Reset, Start, then bits 1,0,1,1,0,0,1 on 7 consecutive BitValid cycles -> Out=7'h4D (7'b1001101); Done high exactly one cycle, the cycle after bit 7; Busy=0 afterwards.
2. Same word with BitValid low for 3 cycles between each bit -> BitIndex holds during gaps; Out=7'h4D; Done one cycle only.
3. Start, 4 bits, Start again, then 7 bits all 0 -> Out=7'h00; previous Out value is unchanged until completion; restart-cycle bit is discarded.
4. Complete word 7'h7F, start a second word, assert Resetn=0 mid-frame between clock edges -> Out=0, BitIndex=0, Busy=0 immediately; Done never pulses.
5. Start asserted during the DONE cycle, followed by 7 bits of 0,1,0,1,0,1,0 -> CAPTURE entered with no IDLE cycle; Out=7'h2A; two Done pulses 8 cycles apart.
6. BitValid toggling in IDLE with SerialIn=1 and no Start -> Out, BitIndex, Busy and Done unchanged.
